// File: rtl/traffic_controller.sv
// Road-crossing game sequencer: per-frame car motion, player/car collision and goal detection.
// Optional pause control is compiled in with `define TRAFFIC_PAUSE_EN.
module traffic_controller #(
   parameter int unsigned H_DISPLAY     = 640,
   parameter int unsigned V_DISPLAY     = 480,
   parameter int unsigned CAR_WIDTH     = 32,
   parameter int unsigned CAR_HEIGHT    = 32,
   parameter int unsigned PLAYER_WIDTH  = 32,
   parameter int unsigned PLAYER_HEIGHT = 32,
   parameter int unsigned LANE_Y1       = 96,
   parameter int unsigned LANE_Y2       = 192,
   parameter int unsigned LANE_Y3       = 288,
   parameter int unsigned LANE_Y4       = 384,
   parameter int unsigned START_X1      = 0,
   parameter int unsigned START_X2      = 160,
   parameter int unsigned START_X3      = 320,
   parameter int unsigned START_X4      = 480,
   parameter int unsigned BASE_SPEED    = 1,
   parameter int unsigned MAX_LEVEL     = 7,
   parameter int unsigned HOLD_FRAMES   = 60
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [9:0] h_count,
   input  logic [9:0] v_count,
   input  logic [9:0] player_x,
   input  logic [9:0] player_y,
   input  logic       start,
   output logic [9:0] car_x,
   output logic [9:0] car_y,
   output logic [9:0] car_x2,
   output logic [9:0] car_y2,
   output logic [9:0] car_x3,
   output logic [9:0] car_y3,
   output logic [9:0] car_x4,
   output logic [9:0] car_y4,
   output logic       collision,
   output logic       level_up,
   output logic [1:0] game_state,
   output logic [2:0] level
`ifdef TRAFFIC_PAUSE_EN
   ,
   input  logic       pause,
   output logic       paused
`endif
);

   localparam int unsigned POS_W   = 10;
   localparam int unsigned SUM_W   = 11;
   localparam int unsigned HOLD_W  = 8;
   localparam int unsigned LEVEL_W = 3;
   localparam int unsigned NUM_CARS = 4;

   localparam logic [NUM_CARS-1:0][POS_W-1:0] START_X =
      {POS_W'(START_X4), POS_W'(START_X3), POS_W'(START_X2), POS_W'(START_X1)};
   localparam logic [NUM_CARS-1:0][POS_W-1:0] LANE_Y =
      {POS_W'(LANE_Y4), POS_W'(LANE_Y3), POS_W'(LANE_Y2), POS_W'(LANE_Y1)};

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_PLAY = 2'b01,
      S_HIT  = 2'b10,
      S_WIN  = 2'b11
   } state_e;

   state_e                         state_q, state_d;
   logic [NUM_CARS-1:0][POS_W-1:0] car_x_q, car_x_d;
   logic [LEVEL_W-1:0]             level_q, level_d;
   logic [HOLD_W-1:0]              hold_q, hold_d;
   logic                           collision_q, collision_d;
   logic                           level_up_q, level_up_d;
   logic                           frame_tick_q, frame_tick_d;
   logic                           paused_q, paused_d;
   logic                           hit_any_c;
   logic                           run_c;
   logic [POS_W-1:0]               speed_c;
   logic [HOLD_W-1:0]              hold_inc_c;

   function automatic logic [POS_W-1:0] move_right(input logic [POS_W-1:0] x,
                                                   input logic [POS_W-1:0] spd);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(x) + SUM_W'(spd);
      if (sum >= SUM_W'(H_DISPLAY)) return POS_W'(sum - SUM_W'(H_DISPLAY));
      return POS_W'(sum);
   endfunction

   function automatic logic [POS_W-1:0] move_left(input logic [POS_W-1:0] x,
                                                  input logic [POS_W-1:0] spd);
      if (x < spd) return POS_W'(SUM_W'(x) + SUM_W'(H_DISPLAY) - SUM_W'(spd));
      return x - spd;
   endfunction

   function automatic logic overlaps(input logic [POS_W-1:0] px, input logic [POS_W-1:0] py,
                                     input logic [POS_W-1:0] cx, input logic [POS_W-1:0] cy);
      return (SUM_W'(px) < SUM_W'(cx) + SUM_W'(CAR_WIDTH))     &&
             (SUM_W'(cx) < SUM_W'(px) + SUM_W'(PLAYER_WIDTH))  &&
             (SUM_W'(py) < SUM_W'(cy) + SUM_W'(CAR_HEIGHT))    &&
             (SUM_W'(cy) < SUM_W'(py) + SUM_W'(PLAYER_HEIGHT));
   endfunction

   // Collision is evaluated against pre-move car positions
   always_comb begin
      hit_any_c = 1'b0;
      for (int i = 0; i < NUM_CARS; i++) begin
         hit_any_c = hit_any_c | overlaps(player_x, player_y, car_x_q[i], LANE_Y[i]);
      end
   end

   assign frame_tick_d = (h_count == POS_W'(0)) && (v_count == POS_W'(V_DISPLAY));
   assign speed_c      = POS_W'(BASE_SPEED) + POS_W'(level_q);
   assign hold_inc_c   = hold_q + HOLD_W'(1);
   assign run_c        = frame_tick_q && !paused_q;

   always_comb begin
      state_d     = state_q;
      car_x_d     = car_x_q;
      level_d     = level_q;
      hold_d      = hold_q;
      collision_d = 1'b0;
      level_up_d  = 1'b0;
      paused_d    = paused_q;
      unique case (state_q)
         S_IDLE: begin
            car_x_d = START_X;
            level_d = '0;
            hold_d  = '0;
            if (start) state_d = S_PLAY;
         end
         S_PLAY: begin
`ifdef TRAFFIC_PAUSE_EN
            if (pause) paused_d = ~paused_q;
`endif
            if (run_c) begin
               if (hit_any_c) begin
                  collision_d = 1'b1;
                  hold_d      = '0;
                  state_d     = S_HIT;
               end else if (player_y == POS_W'(0)) begin
                  level_up_d = 1'b1;
                  hold_d     = '0;
                  state_d    = S_WIN;
               end else begin
                  car_x_d[0] = move_right(car_x_q[0], speed_c);
                  car_x_d[1] = move_left(car_x_q[1], speed_c);
                  car_x_d[2] = move_right(car_x_q[2], speed_c);
                  car_x_d[3] = move_left(car_x_q[3], speed_c);
               end
            end
            if (state_d != S_PLAY) paused_d = 1'b0;
         end
         S_HIT, S_WIN: begin
            if (frame_tick_q) begin
               hold_d = hold_inc_c;
               if (hold_inc_c == HOLD_W'(HOLD_FRAMES)) begin
                  hold_d  = '0;
                  car_x_d = START_X;
                  state_d = S_PLAY;
                  if (state_q == S_HIT) level_d = '0;
                  else if (level_q < LEVEL_W'(MAX_LEVEL)) level_d = level_q + LEVEL_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_IDLE;
         car_x_q      <= START_X;
         level_q      <= '0;
         hold_q       <= '0;
         collision_q  <= 1'b0;
         level_up_q   <= 1'b0;
         frame_tick_q <= 1'b0;
         paused_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         car_x_q      <= car_x_d;
         level_q      <= level_d;
         hold_q       <= hold_d;
         collision_q  <= collision_d;
         level_up_q   <= level_up_d;
         frame_tick_q <= frame_tick_d;
         paused_q     <= paused_d;
      end
   end

   assign car_x      = car_x_q[0];
   assign car_x2     = car_x_q[1];
   assign car_x3     = car_x_q[2];
   assign car_x4     = car_x_q[3];
   assign car_y      = LANE_Y[0];
   assign car_y2     = LANE_Y[1];
   assign car_y3     = LANE_Y[2];
   assign car_y4     = LANE_Y[3];
   assign collision  = collision_q;
   assign level_up   = level_up_q;
   assign game_state = state_q;
   assign level      = level_q;
`ifdef TRAFFIC_PAUSE_EN
   assign paused     = paused_q;
`endif

endmodule
